// File: rtl/npc_seq_ctrl_pkg.sv
// Shared encodings for the NPC sequencer: state codes, halt codes and default geometry.
package npc_seq_ctrl_pkg;

  localparam int          XLEN_DEF     = 64;
  localparam int          INST_W_DEF   = 32;
  localparam logic [63:0] PC_RESET_DEF = 64'h8000_0000;

  localparam logic [2:0] ST_FETCH_REQ  = 3'd0;
  localparam logic [2:0] ST_FETCH_WAIT = 3'd1;
  localparam logic [2:0] ST_DECODE     = 3'd2;
  localparam logic [2:0] ST_EXEC       = 3'd3;
  localparam logic [2:0] ST_WB         = 3'd4;
  localparam logic [2:0] ST_HALT       = 3'd5;

  typedef enum logic [2:0] {
    FETCH_REQ  = ST_FETCH_REQ,
    FETCH_WAIT = ST_FETCH_WAIT,
    DECODE     = ST_DECODE,
    EXEC       = ST_EXEC,
    WB         = ST_WB,
    HALT       = ST_HALT
  } state_e;

  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_EBREAK  = 2'd1;
  localparam logic [1:0] HALT_ILLEGAL = 2'd2;
  localparam logic [1:0] HALT_FAULT   = 2'd3;

  // Instructions are 4-byte aligned; any set low bit is a fault.
  function automatic logic misaligned(input logic [1:0] addr_lo);
    return |addr_lo;
  endfunction

endpackage

// File: rtl/npc_seq_ctrl_if.sv
// Instruction-fetch channel: valid/ready request plus a response with error flag.
interface npc_seq_ctrl_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              ifu_req_valid;
  logic              ifu_req_ready;
  logic [XLEN-1:0]   ifu_addr;
  logic              ifu_rsp_valid;
  logic [INST_W-1:0] ifu_rsp_data;
  logic              ifu_rsp_err;

  modport master (
    output ifu_req_valid, ifu_addr,
    input  ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err
  );

  modport slave (
    input  ifu_req_valid, ifu_addr,
    output ifu_req_ready, ifu_rsp_valid, ifu_rsp_data, ifu_rsp_err
  );

  modport monitor (
    input ifu_req_valid, ifu_req_ready, ifu_rsp_valid
  );
endinterface

// File: rtl/npc_perf_cnt.sv
// 64-bit cycle and retired-instruction counters; cycle counting stops while frozen.
module npc_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc_cycle,
  input  logic        inc_inst,
  input  logic        freeze,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
);

  logic [63:0] cycle_r;
  logic [63:0] instret_r;

  // Counter registers; both wrap naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_r   <= 64'd0;
      instret_r <= 64'd0;
    end else begin
      if (inc_cycle && !freeze) begin
        cycle_r <= cycle_r + 64'd1;
      end else begin
        cycle_r <= cycle_r;
      end
      if (inc_inst) begin
        instret_r <= instret_r + 64'd1;
      end else begin
        instret_r <= instret_r;
      end
    end
  end

  assign cycle_cnt   = cycle_r;
  assign instret_cnt = instret_r;

endmodule

// File: rtl/npc_seq_ctrl_chk.sv
// Fetch-protocol checker: a response is only legal while an accepted fetch is outstanding.
module npc_seq_ctrl_chk (
  input logic             clk,
  input logic             rst_n,
  npc_seq_ctrl_if.monitor ifu
);

  logic pending_r;

  // Tracks an accepted request that has not been answered yet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= 1'b0;
    end else if (ifu.ifu_req_valid && ifu.ifu_req_ready) begin
      pending_r <= 1'b1;
    end else if (ifu.ifu_rsp_valid) begin
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

  // Covers both a same-cycle response and a stray response outside FETCH_WAIT.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rsp_legal: assert (!ifu.ifu_rsp_valid || pending_r);
    end
  end

endmodule

// File: rtl/npc_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the NPC core.
// Owns the PC and instruction register and decides when and why the core halts.
module npc_seq_ctrl
  import npc_seq_ctrl_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] PC_RESET = XLEN'(PC_RESET_DEF),
  parameter int              INST_W   = INST_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  npc_seq_ctrl_if.master    ifu,
  output logic [INST_W-1:0] inst,
  input  logic              dec_is_ebreak,
  input  logic              dec_illegal,
  output logic              exu_en,
  input  logic              exu_done,
  input  logic              npc_sel,
  input  logic [XLEN-1:0]   npc_target,
  output logic              rf_wen,
  output logic [XLEN-1:0]   pc,
  output logic              halted,
  output logic [1:0]        halt_code,
  output logic [63:0]       cycle_cnt,
  output logic [63:0]       instret_cnt
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(3'd4);

  state_e            state_r, state_s;
  logic [XLEN-1:0]   pc_r, pc_s;
  logic [XLEN-1:0]   target_r, target_s;
  logic [INST_W-1:0] inst_r, inst_s;
  logic [1:0]        halt_code_r, halt_code_s;
  logic              exec_first_r, exec_first_s;
  logic              sel_r, sel_s;
  logic              inc_inst_s;

  // Sequencer state and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= FETCH_REQ;
      pc_r         <= PC_RESET;
      inst_r       <= {INST_W{1'b0}};
      target_r     <= {XLEN{1'b0}};
      halt_code_r  <= HALT_NONE;
      exec_first_r <= 1'b0;
      sel_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      inst_r       <= inst_s;
      target_r     <= target_s;
      halt_code_r  <= halt_code_s;
      exec_first_r <= exec_first_s;
      sel_r        <= sel_s;
    end
  end

  // Next-state logic and register updates for each phase.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    inst_s       = inst_r;
    target_s     = target_r;
    halt_code_s  = halt_code_r;
    exec_first_s = 1'b0;
    sel_s        = sel_r;
    inc_inst_s   = 1'b0;
    case (state_r)
      FETCH_REQ: begin
        if (ifu.ifu_req_ready) begin
          state_s = FETCH_WAIT;
        end else begin
          state_s = FETCH_REQ;
        end
      end
      FETCH_WAIT: begin
        if (ifu.ifu_rsp_valid && ifu.ifu_rsp_err) begin
          state_s     = HALT;
          halt_code_s = HALT_FAULT;
        end else if (ifu.ifu_rsp_valid) begin
          inst_s  = ifu.ifu_rsp_data;
          state_s = DECODE;
        end else begin
          state_s = FETCH_WAIT;
        end
      end
      DECODE: begin
        // Illegal wins over ebreak; only ebreak counts as retired.
        if (dec_illegal) begin
          state_s     = HALT;
          halt_code_s = HALT_ILLEGAL;
        end else if (dec_is_ebreak) begin
          state_s     = HALT;
          halt_code_s = HALT_EBREAK;
          inc_inst_s  = 1'b1;
        end else begin
          state_s      = EXEC;
          exec_first_s = 1'b1;
        end
      end
      EXEC: begin
        if (exu_done) begin
          sel_s    = npc_sel;
          target_s = npc_target;
          state_s  = WB;
        end else begin
          state_s = EXEC;
        end
      end
      WB: begin
        inc_inst_s = 1'b1;
        if (sel_r && misaligned(target_r[1:0])) begin
          state_s     = HALT;
          halt_code_s = HALT_FAULT;
        end else begin
          pc_s    = sel_r ? target_r : (pc_r + PC_STEP);
          state_s = FETCH_REQ;
        end
      end
      HALT: begin
        state_s = HALT;
      end
      default: begin
        state_s     = HALT;
        halt_code_s = HALT_FAULT;
      end
    endcase
  end

  assign ifu.ifu_req_valid = (state_r == FETCH_REQ);
  assign ifu.ifu_addr      = pc_r;
  assign exu_en            = (state_r == EXEC) && exec_first_r;
  assign rf_wen            = (state_r == WB);
  assign halted            = (state_r == HALT);
  assign pc                = pc_r;
  assign inst              = inst_r;
  assign halt_code         = halt_code_r;

  npc_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc_cycle   (1'b1),
    .inc_inst    (inc_inst_s),
    .freeze      (halted),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// Directed bench for npc_seq_ctrl: a fetch/execute driver with an expected-retire queue.
module tb_npc_seq_ctrl;
  import npc_seq_ctrl_pkg::*;

  localparam logic [63:0] PC0      = 64'h8000_0000;
  localparam logic [31:0] ADDI_W   = 32'h0050_0093;
  localparam logic [31:0] ADDI2_W  = 32'h00a0_0113;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;
  localparam logic [31:0] ILL_W    = 32'hffff_ffff;

  typedef struct packed {
    logic [31:0] word;
    logic [63:0] pc_next;
    logic [63:0] instret;
    logic        halt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst;
  logic        dec_is_ebreak, dec_illegal;
  logic        exu_en, exu_done, npc_sel, rf_wen, halted;
  logic [63:0] npc_target, pc, cycle_cnt, instret_cnt;
  logic [1:0]  halt_code;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [63:0] model_pc, model_instret;
  logic [31:0] model_inst;

  npc_seq_ctrl_if #(.XLEN(64), .INST_W(32)) ifu_bus ();

  npc_seq_ctrl #(.XLEN(64), .PC_RESET(PC0), .INST_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ifu           (ifu_bus),
    .inst          (inst),
    .dec_is_ebreak (dec_is_ebreak),
    .dec_illegal   (dec_illegal),
    .exu_en        (exu_en),
    .exu_done      (exu_done),
    .npc_sel       (npc_sel),
    .npc_target    (npc_target),
    .rf_wen        (rf_wen),
    .pc            (pc),
    .halted        (halted),
    .halt_code     (halt_code),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

  npc_seq_ctrl_chk chk (.clk(clk), .rst_n(rst_n), .ifu(ifu_bus));

  always #5 clk = ~clk;

  // Decoder stand-in: ILL_W raises both flags so illegal priority is exercised.
  assign dec_is_ebreak = (inst == EBREAK_W) || (inst == ILL_W);
  assign dec_illegal   = (inst == ILL_W);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    ifu_bus.ifu_req_ready = 1'b0;
    ifu_bus.ifu_rsp_valid = 1'b0;
    ifu_bus.ifu_rsp_data  = 32'd0;
    ifu_bus.ifu_rsp_err   = 1'b0;
    exu_done   = 1'b0;
    npc_sel    = 1'b0;
    npc_target = 64'd0;
  endtask

  task automatic reset_model();
    model_pc      = PC0;
    model_instret = 64'd0;
    model_inst    = 32'd0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic fetch_word(input logic [31:0] w, input int rdy_dly, input int rsp_dly, input logic bad);
    int n;
    n = 0;
    while (ifu_bus.ifu_req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("req_valid", ifu_bus.ifu_req_valid, 1'b1);
    check("ifu_addr", ifu_bus.ifu_addr, model_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      check("addr_stable", ifu_bus.ifu_addr, model_pc);
    end
    ifu_bus.ifu_req_ready = 1'b1;
    tick();
    ifu_bus.ifu_req_ready = 1'b0;
    check("req_dropped", ifu_bus.ifu_req_valid, 1'b0);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
      check("inst_hold", inst, model_inst);
    end
    ifu_bus.ifu_rsp_valid = 1'b1;
    ifu_bus.ifu_rsp_data  = w;
    ifu_bus.ifu_rsp_err   = bad;
    tick();
    ifu_bus.ifu_rsp_valid = 1'b0;
    ifu_bus.ifu_rsp_err   = 1'b0;
    if (!bad) model_inst = w;
    check("inst_latch", inst, model_inst);
  endtask

  task automatic run_inst(input logic [31:0] w, input int rdy_dly, input int rsp_dly,
                          input logic sel, input logic [63:0] tgt);
    exp_t e, got;
    fetch_word(w, rdy_dly, rsp_dly, 1'b0);
    e.word    = w;
    e.halt    = sel && (tgt[1:0] != 2'b00);
    e.pc_next = e.halt ? model_pc : (sel ? tgt : model_pc + 64'd4);
    model_instret = model_instret + 64'd1;
    e.instret = model_instret;
    model_pc  = e.pc_next;
    exp_q.push_back(e);
    tick();
    check("exu_en", exu_en, 1'b1);
    exu_done   = 1'b1;
    npc_sel    = sel;
    npc_target = tgt;
    tick();
    exu_done   = 1'b0;
    npc_sel    = 1'b0;
    npc_target = 64'd0;
    check("rf_wen", rf_wen, 1'b1);
    check("exu_en_pulse", exu_en, 1'b0);
    check("sb_nonempty", exp_q.size(), 64'd1);
    if (exp_q.size() > 0) got = exp_q.pop_front();
    else got = e;
    check("rf_inst", inst, got.word);
    tick();
    check("rf_wen_drop", rf_wen, 1'b0);
    check("pc", pc, got.pc_next);
    check("instret", instret_cnt, got.instret);
    check("halted", halted, got.halt);
    if (got.halt) check("halt_code_fault", halt_code, HALT_FAULT);
    else check("next_addr", ifu_bus.ifu_addr, got.pc_next);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int viol;
    clear_inputs();
    reset_model();
    tick();
    check("rst_pc", pc, PC0);
    check("rst_inst", inst, 32'd0);
    check("rst_halted", halted, 1'b0);
    check("rst_rf_wen", rf_wen, 1'b0);
    check("rst_exu_en", exu_en, 1'b0);
    check("rst_halt_code", halt_code, HALT_NONE);
    check("rst_cycle", cycle_cnt, 64'd0);
    check("rst_instret", instret_cnt, 64'd0);
    tick();
    rst_n = 1'b1;

    // Zero-wait fetch, one-cycle execute: retire lands in cycle 5.
    run_inst(ADDI_W, 0, 0, 1'b0, 64'd0);
    check("a_pc", pc, 64'h8000_0004);
    check("a_cycle", cycle_cnt, 64'd5);

    // Back-pressured request and late response.
    do_reset();
    run_inst(ADDI2_W, 3, 2, 1'b0, 64'd0);
    check("b_cycle", cycle_cnt, 64'd10);

    // Aligned redirect, then a misaligned one that faults.
    run_inst(ADDI_W, 0, 0, 1'b1, 64'h8000_0100);
    check("c_addr", ifu_bus.ifu_addr, 64'h8000_0100);
    run_inst(ADDI_W, 0, 0, 1'b1, 64'h8000_0102);
    check("c_pc_kept", pc, 64'h8000_0100);
    check("c_instret", instret_cnt, 64'd3);

    // ebreak halts from DECODE and freezes the cycle counter.
    do_reset();
    fetch_word(EBREAK_W, 0, 0, 1'b0);
    tick();
    check("e_halted", halted, 1'b1);
    check("e_code", halt_code, HALT_EBREAK);
    check("e_instret", instret_cnt, 64'd1);
    check("e_cycle", cycle_cnt, 64'd3);
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      if (exu_en !== 1'b0 || rf_wen !== 1'b0 || ifu_bus.ifu_req_valid !== 1'b0) viol++;
      tick();
    end
    check("e_strobes", viol, 64'd0);
    check("e_cycle_frozen", cycle_cnt, 64'd3);
    check("e_still_halted", halted, 1'b1);

    // Illegal beats ebreak and does not retire.
    do_reset();
    fetch_word(ILL_W, 0, 0, 1'b0);
    tick();
    check("i_halted", halted, 1'b1);
    check("i_code", halt_code, HALT_ILLEGAL);
    check("i_instret", instret_cnt, 64'd0);
    check("i_exu_en", exu_en, 1'b0);

    // Bus error on the second fetch keeps the first word.
    do_reset();
    run_inst(ADDI_W, 0, 0, 1'b0, 64'd0);
    fetch_word(ADDI2_W, 0, 0, 1'b1);
    check("f_halted", halted, 1'b1);
    check("f_code", halt_code, HALT_FAULT);
    check("f_inst", inst, ADDI_W);
    check("f_instret", instret_cnt, 64'd1);

    // Asynchronous reset while a fetch is outstanding.
    do_reset();
    run_inst(ADDI_W, 0, 0, 1'b0, 64'd0);
    ifu_bus.ifu_req_ready = 1'b1;
    tick();
    ifu_bus.ifu_req_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("r_pc", pc, PC0);
    check("r_cycle", cycle_cnt, 64'd0);
    check("r_instret", instret_cnt, 64'd0);
    check("r_inst", inst, 32'd0);
    check("r_halted", halted, 1'b0);
    tick();
    rst_n = 1'b1;
    reset_model();
    check("r_req_valid", ifu_bus.ifu_req_valid, 1'b1);
    check("r_addr", ifu_bus.ifu_addr, PC0);
    run_inst(ADDI2_W, 1, 1, 1'b0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
